// File: rtl/locked_vector_harness.sv
// locked_vector_harness: walks a vector ROM of (a, b, golden z) entries, issues each pair to an
// external multi-cycle core over a start/done handshake, and counts mismatches against z.
// Per-vector timeout, optional stop at the first mismatch, and key-locked FSM transitions.
module locked_vector_harness #(
  parameter int unsigned      DATA_W   = 64,
  parameter int unsigned      NUM_VEC  = 20,
  parameter int unsigned      ADDR_W   = 5,
  parameter int unsigned      CNT_W    = 8,
  parameter int unsigned      TIMEOUT  = 1024,
  parameter int unsigned      KEY_W    = 6,
  parameter logic [KEY_W-1:0] KEY_GOLD = KEY_W'(6'b101101)
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              ap_start,
  output logic              ap_done,
  output logic              ap_idle,
  output logic              ap_ready,
  output logic [CNT_W-1:0]  ap_return,
  input  logic [KEY_W-1:0]  working_key,
  input  logic              stop_on_fail,
  output logic [ADDR_W-1:0] vec_addr,
  output logic              vec_ce,
  input  logic [DATA_W-1:0] vec_a,
  input  logic [DATA_W-1:0] vec_b,
  input  logic [DATA_W-1:0] vec_z,
  output logic              core_start,
  output logic [DATA_W-1:0] core_a,
  output logic [DATA_W-1:0] core_b,
  input  logic              core_done,
  input  logic [DATA_W-1:0] core_result,
  output logic [ADDR_W-1:0] fail_idx,
  output logic              timeout_flag
);

  // idx needs one extra bit so it can reach NUM_VEC even when NUM_VEC == 2**ADDR_W.
  localparam int unsigned IdxW   = ADDR_W + 1;
  localparam int unsigned TimerW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [IdxW-1:0]   NumVecIdx = IdxW'(NUM_VEC);
  localparam logic [TimerW-1:0] TimerMax  = TimerW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StIssue,
    StWait
  } state_e;

  state_e              state_q;
  logic [IdxW-1:0]     idx_q;
  logic [CNT_W-1:0]    count_q;
  logic [ADDR_W-1:0]   fail_idx_q;
  logic                timeout_q;
  logic                stop_q;
  logic [TimerW-1:0]   timer_q;
  logic [DATA_W-1:0]   core_a_q;
  logic [DATA_W-1:0]   core_b_q;
  logic [DATA_W-1:0]   gold_z_q;
  logic                done_q;
  logic                core_start_q;
  logic                vec_ce_q;
  logic [ADDR_W-1:0]   vec_addr_q;

  logic [2:0]          key_bad;
  logic                div_l1;
  logic                div_l2;
  logic [IdxW-1:0]     idx_inc;
  logic                idx_inc_last;
  logic                timer_hit;
  logic                wait_evt;
  logic                wait_tmo;
  logic                wait_mism;

  // Lock slices: each 2-bit key slice guards one transition of the vector walk.
  assign key_bad[0] = (working_key[1:0] != KEY_GOLD[1:0]);
  assign key_bad[1] = (working_key[3:2] != KEY_GOLD[3:2]);
  assign key_bad[2] = (working_key[5:4] != KEY_GOLD[5:4]);

  assign div_l1 = key_bad[1] && (idx_q[1:0] == 2'd1);
  assign div_l2 = key_bad[2] && (idx_q[1:0] == 2'd2);

  assign idx_inc      = idx_q + 1'b1;
  assign idx_inc_last = (idx_inc == NumVecIdx);

  // A done arriving on the timeout cycle wins over the timeout.
  assign timer_hit = (timer_q == TimerMax);
  assign wait_evt  = core_done || timer_hit;
  assign wait_tmo  = timer_hit && !core_done;
  assign wait_mism = core_done ? (core_result != gold_z_q) : 1'b1;

  // Main FSM with all handshake outputs registered.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      count_q      <= '0;
      fail_idx_q   <= '1;
      timeout_q    <= 1'b0;
      stop_q       <= 1'b0;
      timer_q      <= '0;
      core_a_q     <= '0;
      core_b_q     <= '0;
      gold_z_q     <= '0;
      done_q       <= 1'b0;
      core_start_q <= 1'b0;
      vec_ce_q     <= 1'b0;
      vec_addr_q   <= '0;
    end else begin
      done_q       <= 1'b0;
      core_start_q <= 1'b0;
      vec_ce_q     <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (ap_start) begin
            idx_q      <= '0;
            count_q    <= '0;
            timeout_q  <= 1'b0;
            fail_idx_q <= '1;
            stop_q     <= stop_on_fail;
            timer_q    <= '0;
            // The new idx is 0, so lock L0 applies whenever its slice is wrong.
            if (key_bad[0]) begin
              state_q <= StWait;
            end else begin
              state_q    <= StFetch;
              vec_ce_q   <= 1'b1;
              vec_addr_q <= '0;
            end
          end
        end
        StFetch: begin
          // ap_done for the final FETCH was raised on entry.
          if (idx_q == NumVecIdx) begin
            state_q <= StIdle;
          end else if (div_l1) begin
            state_q <= StWait;
            timer_q <= '0;
          end else begin
            state_q <= StLoad;
          end
        end
        StLoad: begin
          core_a_q <= vec_a;
          core_b_q <= vec_b;
          gold_z_q <= vec_z;
          if (div_l2) begin
            state_q <= StWait;
            timer_q <= '0;
          end else begin
            state_q <= StIssue;
          end
        end
        StIssue: begin
          core_start_q <= 1'b1;
          timer_q      <= '0;
          state_q      <= StWait;
        end
        StWait: begin
          if (wait_evt) begin
            idx_q <= idx_inc;
            if (wait_mism) begin
              if (count_q != '1) begin
                count_q <= count_q + 1'b1;
              end
              if (fail_idx_q == '1) begin
                fail_idx_q <= idx_q[ADDR_W-1:0];
              end
            end
            if (wait_tmo) begin
              timeout_q <= 1'b1;
            end
            if (wait_mism && stop_q) begin
              done_q  <= 1'b1;
              state_q <= StIdle;
            end else begin
              state_q <= StFetch;
              if (idx_inc_last) begin
                done_q <= 1'b1;
              end else begin
                vec_ce_q   <= 1'b1;
                vec_addr_q <= idx_inc[ADDR_W-1:0];
              end
            end
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign ap_idle      = (state_q == StIdle) && !ap_start;
  assign ap_done      = done_q;
  assign ap_ready     = done_q;
  assign ap_return    = count_q;
  assign vec_addr     = vec_addr_q;
  assign vec_ce       = vec_ce_q;
  assign core_start   = core_start_q;
  assign core_a       = core_a_q;
  assign core_b       = core_b_q;
  assign fail_idx     = fail_idx_q;
  assign timeout_flag = timeout_q;

endmodule

// File: tb/tb_locked_vector_harness.sv
// Directed bench for locked_vector_harness: ROM model, adder-style core model with adjustable
// latency and per-vector result corruption, and a second instance with a 2-bit counter.
module tb_locked_vector_harness;

  localparam int DW  = 64;
  localparam int AW  = 5;
  localparam int KW  = 6;
  localparam logic [KW-1:0] KG = 6'b101101;

  logic           ap_clk = 1'b0;
  logic           ap_rst = 1'b1;
  logic           ap_start = 1'b0;
  logic           stop_on_fail = 1'b0;
  logic [KW-1:0]  working_key = KG;
  logic [DW-1:0]  vec_a = '0, vec_b = '0, vec_z = '0;
  logic           core_done = 1'b0;
  logic [DW-1:0]  core_result = '0;

  logic           ap_done, ap_idle, ap_ready, vec_ce, core_start, timeout_flag;
  logic [7:0]     ap_return;
  logic [AW-1:0]  vec_addr, fail_idx;
  logic [DW-1:0]  core_a, core_b;

  logic           s_done, s_idle, s_ready, s_vec_ce, s_core_start, s_timeout_flag;
  logic [1:0]     s_return;
  logic [AW-1:0]  s_vec_addr, s_fail_idx;
  logic [DW-1:0]  s_core_a, s_core_b;

  int errors = 0;
  int checks = 0;

  always #5 ap_clk = ~ap_clk;

  locked_vector_harness #(.TIMEOUT(16)) u_dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start), .ap_done(ap_done),
    .ap_idle(ap_idle), .ap_ready(ap_ready), .ap_return(ap_return),
    .working_key(working_key), .stop_on_fail(stop_on_fail), .vec_addr(vec_addr),
    .vec_ce(vec_ce), .vec_a(vec_a), .vec_b(vec_b), .vec_z(vec_z), .core_start(core_start),
    .core_a(core_a), .core_b(core_b), .core_done(core_done), .core_result(core_result),
    .fail_idx(fail_idx), .timeout_flag(timeout_flag)
  );

  // Lockstep twin with a 2-bit mismatch counter to exercise saturation.
  locked_vector_harness #(.TIMEOUT(16), .CNT_W(2)) u_sat (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start), .ap_done(s_done),
    .ap_idle(s_idle), .ap_ready(s_ready), .ap_return(s_return),
    .working_key(working_key), .stop_on_fail(stop_on_fail), .vec_addr(s_vec_addr),
    .vec_ce(s_vec_ce), .vec_a(vec_a), .vec_b(vec_b), .vec_z(vec_z), .core_start(s_core_start),
    .core_a(s_core_a), .core_b(s_core_b), .core_done(core_done), .core_result(core_result),
    .fail_idx(s_fail_idx), .timeout_flag(s_timeout_flag)
  );

  // Vector ROM: golden z is a + b.
  logic [DW-1:0] rom_a [32];
  logic [DW-1:0] rom_b [32];

  always @(posedge ap_clk) begin
    if (vec_ce) begin
      vec_a <= rom_a[vec_addr];
      vec_b <= rom_b[vec_addr];
      vec_z <= rom_a[vec_addr] + rom_b[vec_addr];
    end
  end

  // Core model: adds operands, done `lat` cycles after the cycle start is seen.
  int            lat = 3;
  bit            never_done = 1'b0;
  logic [31:0]   corrupt = '0;
  int            run_base = 0;
  int            starts_total = 0;
  int            dones_total = 0;
  int            rem = 0;
  logic [DW-1:0] pend = '0;

  always @(posedge ap_clk) begin
    int r;
    int vi;
    logic [DW-1:0] fresh;
    fresh = core_a + core_b;
    vi = starts_total - run_base;
    if (vi >= 0 && vi < 32 && corrupt[vi]) fresh = fresh ^ 64'h1;
    r = core_start ? lat : rem;
    if (core_start) begin
      pend <= fresh;
      starts_total <= starts_total + 1;
    end
    if (r == 1 && !never_done) begin
      core_done   <= 1'b1;
      core_result <= core_start ? fresh : pend;
    end else begin
      core_done   <= 1'b0;
      core_result <= 64'hDEAD_BEEF_0BAD_F00D;
    end
    rem <= (r > 0) ? r - 1 : 0;
    if (ap_done) dones_total <= dones_total + 1;
  end

  // One run: pulse ap_start, wait (bounded) for ap_done, then idle a few cycles.
  // cycles counts from the ap_start cycle to the ap_done cycle inclusive.
  task automatic run_once(input bit stop, output int cycles, output bit ok, output logic rdy,
                          output int n_starts, output int n_dones);
    int n;
    int d0;
    run_base = starts_total;
    d0 = dones_total;
    stop_on_fail = stop;
    ap_start = 1'b1;
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
    n = 2;
    while (ap_done !== 1'b1 && n < 3000) begin
      @(posedge ap_clk); #1;
      n++;
    end
    cycles = n;
    ok = (ap_done === 1'b1);
    rdy = ap_ready;
    repeat (5) @(posedge ap_clk);
    #1;
    n_starts = starts_total - run_base;
    n_dones = dones_total - d0;
  endtask

  task automatic test_reset();
    ap_rst = 1'b1;
    repeat (3) @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    checks++; if (ap_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", ap_done); end
    checks++; if (ap_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", ap_ready); end
    checks++; if (ap_idle !== 1'b1) begin errors++; $display("FAIL reset_idle got %b want 1", ap_idle); end
    checks++; if (vec_ce !== 1'b0) begin errors++; $display("FAIL reset_vec_ce got %b want 0", vec_ce); end
    checks++; if (core_start !== 1'b0) begin errors++; $display("FAIL reset_core_start got %b want 0", core_start); end
    checks++; if (timeout_flag !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b want 0", timeout_flag); end
    checks++; if (ap_return !== 8'd0) begin errors++; $display("FAIL reset_return got %0d want 0", ap_return); end
    checks++; if (fail_idx !== 5'h1F) begin errors++; $display("FAIL reset_fail_idx got %h want 1f", fail_idx); end
    checks++; if (core_a !== 64'd0 || core_b !== 64'd0) begin
      errors++; $display("FAIL reset_operands got %h/%h want 0/0", core_a, core_b);
    end
  endtask

  task automatic test_golden();
    int cyc, ns, nd; bit ok; logic rdy;
    lat = 3; corrupt = '0; never_done = 1'b0;
    run_once(1'b0, cyc, ok, rdy, ns, nd);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL golden_done_seen got %b want 1", ok); end
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL golden_ready got %b want 1", rdy); end
    checks++; if (cyc != 142) begin errors++; $display("FAIL golden_latency got %0d want 142", cyc); end
    checks++; if (nd != 1) begin errors++; $display("FAIL golden_done_count got %0d want 1", nd); end
    checks++; if (ns != 20) begin errors++; $display("FAIL golden_starts got %0d want 20", ns); end
    checks++; if (ap_return !== 8'd0) begin errors++; $display("FAIL golden_return got %0d want 0", ap_return); end
    checks++; if (fail_idx !== 5'h1F) begin errors++; $display("FAIL golden_fail_idx got %h want 1f", fail_idx); end
    checks++; if (timeout_flag !== 1'b0) begin errors++; $display("FAIL golden_timeout got %b want 0", timeout_flag); end
  endtask

  task automatic test_mismatch();
    int cyc, ns, nd; bit ok; logic rdy;
    lat = 3; corrupt = 32'h0000_0088; never_done = 1'b0;
    run_once(1'b0, cyc, ok, rdy, ns, nd);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL mism_done_seen got %b want 1", ok); end
    checks++; if (ns != 20) begin errors++; $display("FAIL mism_starts got %0d want 20", ns); end
    checks++; if (ap_return !== 8'd2) begin errors++; $display("FAIL mism_return got %0d want 2", ap_return); end
    checks++; if (fail_idx !== 5'd3) begin errors++; $display("FAIL mism_fail_idx got %0d want 3", fail_idx); end
    repeat (10) @(posedge ap_clk);
    #1;
    checks++; if (ap_return !== 8'd2) begin errors++; $display("FAIL mism_return_hold got %0d want 2", ap_return); end
  endtask

  task automatic test_stop_on_fail();
    int cyc, ns, nd; bit ok; logic rdy;
    lat = 3; corrupt = 32'h0000_0088; never_done = 1'b0;
    run_once(1'b1, cyc, ok, rdy, ns, nd);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL stop_done_seen got %b want 1", ok); end
    checks++; if (nd != 1) begin errors++; $display("FAIL stop_done_count got %0d want 1", nd); end
    checks++; if (ns != 4) begin errors++; $display("FAIL stop_starts got %0d want 4", ns); end
    checks++; if (ap_return !== 8'd1) begin errors++; $display("FAIL stop_return got %0d want 1", ap_return); end
    checks++; if (fail_idx !== 5'd3) begin errors++; $display("FAIL stop_fail_idx got %0d want 3", fail_idx); end
  endtask

  task automatic test_timeout();
    int cyc, ns, nd; bit ok; logic rdy;
    // Core silent: every vector spends 16 WAIT cycles.
    corrupt = '0; never_done = 1'b1; lat = 3;
    run_once(1'b0, cyc, ok, rdy, ns, nd);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL tmo_done_seen got %b want 1", ok); end
    checks++; if (cyc != 382) begin errors++; $display("FAIL tmo_latency got %0d want 382", cyc); end
    checks++; if (timeout_flag !== 1'b1) begin errors++; $display("FAIL tmo_flag got %b want 1", timeout_flag); end
    checks++; if (ap_return !== 8'd20) begin errors++; $display("FAIL tmo_return got %0d want 20", ap_return); end
    checks++; if (fail_idx !== 5'd0) begin errors++; $display("FAIL tmo_fail_idx got %0d want 0", fail_idx); end
    // Done lands exactly on the last timer cycle: counts as done.
    never_done = 1'b0; lat = 15;
    run_once(1'b0, cyc, ok, rdy, ns, nd);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL edge_done_seen got %b want 1", ok); end
    checks++; if (cyc != 382) begin errors++; $display("FAIL edge_latency got %0d want 382", cyc); end
    checks++; if (timeout_flag !== 1'b0) begin errors++; $display("FAIL edge_flag got %b want 0", timeout_flag); end
    checks++; if (ap_return !== 8'd0) begin errors++; $display("FAIL edge_return got %0d want 0", ap_return); end
  endtask

  task automatic test_key_lock();
    int cyc, ns, nd; bit ok; logic rdy;
    // L1 wrong: vectors 1,5,9,13,17 divert to WAIT, skip ISSUE and time out.
    lat = 3; corrupt = '0; never_done = 1'b0;
    working_key = KG ^ 6'b000100;
    run_once(1'b0, cyc, ok, rdy, ns, nd);
    working_key = KG;
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL key_done_seen got %b want 1", ok); end
    checks++; if (ns != 15) begin errors++; $display("FAIL key_starts got %0d want 15", ns); end
    checks++; if (ap_return !== 8'd5) begin errors++; $display("FAIL key_return got %0d want 5", ap_return); end
    checks++; if (fail_idx !== 5'd1) begin errors++; $display("FAIL key_fail_idx got %0d want 1", fail_idx); end
    checks++; if (timeout_flag !== 1'b1) begin errors++; $display("FAIL key_flag got %b want 1", timeout_flag); end
    checks++; if (cyc != 192) begin errors++; $display("FAIL key_latency got %0d want 192", cyc); end
  endtask

  task automatic test_saturation();
    int cyc, ns, nd; bit ok; logic rdy;
    lat = 3; corrupt = 32'h0001_1111; never_done = 1'b0;
    run_once(1'b0, cyc, ok, rdy, ns, nd);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL sat_done_seen got %b want 1", ok); end
    checks++; if (ap_return !== 8'd5) begin errors++; $display("FAIL sat_wide_return got %0d want 5", ap_return); end
    checks++; if (s_return !== 2'd3) begin errors++; $display("FAIL sat_narrow_return got %0d want 3", s_return); end
    checks++; if (s_fail_idx !== 5'd0) begin errors++; $display("FAIL sat_fail_idx got %0d want 0", s_fail_idx); end
  endtask

  task automatic test_reset_mid_run();
    int n, s0, d0, cyc, ns, nd; bit ok; logic rdy;
    lat = 2; corrupt = 32'h1; never_done = 1'b0;
    run_base = starts_total;
    stop_on_fail = 1'b0;
    ap_start = 1'b1;
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
    n = 0;
    while (starts_total - run_base < 3 && n < 500) begin
      @(posedge ap_clk); #1;
      n++;
    end
    checks++; if (n >= 500) begin errors++; $display("FAIL rst_reach_wait got %0d cycles want <500", n); end
    checks++; if (ap_return !== 8'd1) begin errors++; $display("FAIL rst_pre_return got %0d want 1", ap_return); end
    ap_rst = 1'b1;
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;
    checks++; if (ap_idle !== 1'b1) begin errors++; $display("FAIL rst_idle got %b want 1", ap_idle); end
    checks++; if (ap_return !== 8'd0) begin errors++; $display("FAIL rst_return got %0d want 0", ap_return); end
    checks++; if (ap_done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", ap_done); end
    checks++; if (fail_idx !== 5'h1F) begin errors++; $display("FAIL rst_fail_idx got %h want 1f", fail_idx); end
    s0 = starts_total; d0 = dones_total;
    repeat (20) @(posedge ap_clk);
    #1;
    checks++; if (starts_total != s0) begin errors++; $display("FAIL rst_no_restart got %0d want 0", starts_total - s0); end
    checks++; if (dones_total != d0) begin errors++; $display("FAIL rst_no_done got %0d want 0", dones_total - d0); end
    corrupt = '0;
    run_once(1'b0, cyc, ok, rdy, ns, nd);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rerun_done_seen got %b want 1", ok); end
    checks++; if (ns != 20) begin errors++; $display("FAIL rerun_starts got %0d want 20", ns); end
    checks++; if (ap_return !== 8'd0) begin errors++; $display("FAIL rerun_return got %0d want 0", ap_return); end
    checks++; if (cyc != 122) begin errors++; $display("FAIL rerun_latency got %0d want 122", cyc); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      rom_a[i] = {32'(i * 7 + 3), 32'h1000_0000 + 32'(i)};
      rom_b[i] = {32'h00C0_FFEE, 32'(i * i + 11)};
    end
    test_reset();
    test_golden();
    test_mismatch();
    test_stop_on_fail();
    test_timeout();
    test_key_lock();
    test_saturation();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
